// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the two-digit scan controller.
package seven_seg_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW_LS = 3'd1,
        BLANK_A = 3'd2,
        SHOW_MS = 3'd3,
        BLANK_B = 3'd4
    } state_t;

    typedef struct packed {
        logic [NIB_W-1:0] ms;
        logic [NIB_W-1:0] ls;
    } digits_t;

    localparam logic [SEG_W-1:0] SEG_OFF_AL = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;

    // Active-high {g,f,e,d,c,b,a} pattern for 0-F (lower-case b and d).
    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] pat;
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble to active-high segment pattern; polarity is applied by the caller.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = seg_decode(nibble);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Two-digit seven-segment scan controller: dwell/blank sequencing, frame-aligned
// value updates, hex decode and optional leading-zero blanking.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES   = 12000,
    parameter int unsigned BLANK_CYCLES   = 120,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NIB_W-1:0] nibble_ms,
    input  logic [NIB_W-1:0] nibble_ls,
    input  logic             load,
    input  logic             lz_blank,
    output logic [SEG_W-1:0] seg,
    output logic             dig_sel,
    output logic             frame_tick
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SEG_W-1:0] SEG_OFF    = SEG_ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digits_t          stage_q, stage_d;
    digits_t          shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dig_sel_q, dig_sel_d;
    logic             frame_tick_q, frame_tick_d;

    digits_t          nibbles_in;
    logic [NIB_W-1:0] dec_nibble;
    logic [SEG_W-1:0] dec_pattern_c;
    logic [SEG_W-1:0] seg_on;

    assign nibbles_in = '{ms: nibble_ms, ls: nibble_ls};

    // Sequencing and dwell counter; enable low forces IDLE from any state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_tick_d = 1'b0;
        case (state_q)
            IDLE:    if (enable) state_d = SHOW_LS;
            SHOW_LS: if (cnt_q == DIGIT_LAST) state_d = BLANK_A;
            BLANK_A: if (cnt_q == BLANK_LAST) state_d = SHOW_MS;
            SHOW_MS: if (cnt_q == DIGIT_LAST) state_d = BLANK_B;
            BLANK_B: if (cnt_q == BLANK_LAST) state_d = SHOW_LS;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        frame_tick_d = (state_d == SHOW_LS) && (state_q != SHOW_LS);
    end

    // frame_tick_q marks the boundary cycle: pending values commit, a same-cycle load bypasses.
    always_comb begin
        stage_d   = stage_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_tick_q) begin
            if (load) begin
                stage_d  = nibbles_in;
                shadow_d = nibbles_in;
            end else if (pending_q) begin
                shadow_d = stage_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            stage_d   = nibbles_in;
            pending_d = 1'b1;
        end
    end

    // Decode from the next shadow so a boundary update is visible for the whole frame.
    assign dec_nibble = (state_q == SHOW_MS) ? shadow_d.ms : shadow_d.ls;

    seven_seg_decode u_decode (
        .nibble    (dec_nibble),
        .pattern_c (dec_pattern_c)
    );

    assign seg_on = SEG_ACTIVE_LOW ? ~dec_pattern_c : dec_pattern_c;

    // Segment/select outputs lag the state register by one cycle; dig_sel only moves with a lit digit.
    always_comb begin
        seg_d     = SEG_OFF;
        dig_sel_d = dig_sel_q;
        case (state_q)
            SHOW_LS: begin
                seg_d     = seg_on;
                dig_sel_d = 1'b0;
            end
            SHOW_MS: begin
                dig_sel_d = 1'b1;
                seg_d     = (lz_blank && (shadow_d.ms == '0)) ? SEG_OFF : seg_on;
            end
            default: begin
                seg_d     = SEG_OFF;
                dig_sel_d = dig_sel_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stage_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_sel_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a frame-position reference model predicts each
// cycle's outputs into a queue and a negedge monitor pops and compares them.
module tb_seven_seg_scan;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int FRAME = 2 * (D + B);

    typedef struct {
        logic [6:0] seg;
        logic       dig;
        logic       ft;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] nibble_ms;
    logic [3:0] nibble_ls;
    logic       load;
    logic       lz_blank;
    logic [6:0] seg;
    logic       dig_sel;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb[$];

    // Reference model state: position within the frame, -1 when dark/idle.
    int         m_pos     = -1;
    logic [3:0] m_stage_ms, m_stage_ls, m_shadow_ms, m_shadow_ls;
    bit         m_pend    = 1'b0;
    logic       m_dig     = 1'b0;

    seven_seg_scan #(
        .DIGIT_CYCLES   (D),
        .BLANK_CYCLES   (B),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .nibble_ms  (nibble_ms),
        .nibble_ls  (nibble_ls),
        .load       (load),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lit(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return ~p;
    endfunction

    // One clock edge of the reference model; predicts outputs for the following cycle.
    task automatic model_step();
        exp_t e;
        if (rst) begin
            m_pos = -1;
            m_stage_ms = 4'h0; m_stage_ls = 4'h0;
            m_shadow_ms = 4'h0; m_shadow_ls = 4'h0;
            m_pend = 1'b0;
            m_dig  = 1'b0;
            e.seg = 7'h7F; e.dig = 1'b0; e.ft = 1'b0;
        end else begin
            if (m_pos == 0) begin
                if (load) begin
                    m_shadow_ms = nibble_ms; m_shadow_ls = nibble_ls;
                end else if (m_pend) begin
                    m_shadow_ms = m_stage_ms; m_shadow_ls = m_stage_ls;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_stage_ms = nibble_ms; m_stage_ls = nibble_ls;
                m_pend = 1'b1;
            end
            e.seg = 7'h7F;
            if (m_pos >= 0 && m_pos < D) begin
                e.seg = lit(m_shadow_ls);
                m_dig = 1'b0;
            end else if (m_pos >= D + B && m_pos < 2 * D + B) begin
                m_dig = 1'b1;
                e.seg = (lz_blank && m_shadow_ms == 4'h0) ? 7'h7F : lit(m_shadow_ms);
            end
            e.dig = m_dig;
            if (!enable)       m_pos = -1;
            else if (m_pos < 0) m_pos = 0;
            else               m_pos = (m_pos + 1) % FRAME;
            e.ft = (m_pos == 0);
        end
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: every cycle is an output beat; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (seg !== e.seg) begin
                    errors++;
                    $display("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, e.seg);
                end
                checks++;
                if (dig_sel !== e.dig) begin
                    errors++;
                    $display("FAIL dig_sel cyc=%0d got=%b exp=%b", cyc, dig_sel, e.dig);
                end
                checks++;
                if (frame_tick !== e.ft) begin
                    errors++;
                    $display("FAIL frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, e.ft);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_tick cyc=%0d got=no_tick exp=tick", cyc);
        end
    endtask

    task automatic pulse_load(input logic [3:0] ms, input logic [3:0] ls);
        nibble_ms = ms;
        nibble_ls = ls;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        nibble_ms = 4'($urandom);
        nibble_ls = 4'($urandom);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; lz_blank = 1'b0;
        nibble_ms = 4'h0; nibble_ls = 4'h0;
        step(3);
        rst = 1'b0;
        step(3);

        // Free-running scan showing 0/0.
        enable = 1'b1;
        step(30);

        // Load mid-SHOW_MS takes effect at the next frame.
        wait_tick();
        step(7);
        pulse_load(4'h3, 4'hA);
        step(30);

        // Load on the boundary cycle bypasses into the current frame.
        wait_tick();
        pulse_load(4'h1, 4'h2);
        step(14);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        pulse_load(4'h0, 4'h5);
        step(26);
        pulse_load(4'h7, 4'h5);
        step(26);
        lz_blank = 1'b0;

        // Enable dropped during SHOW_MS, then restored.
        wait_tick();
        step(7);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        step(14);

        // Reset mid-BLANK_A with a pending load.
        wait_tick();
        step(4);
        pulse_load(4'h9, 4'h8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(26);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            nibble_ms = 4'($urandom);
            nibble_ls = 4'($urandom);
            load      = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 2) lz_blank = ~lz_blank;
            if ($urandom_range(0, 199) < 3) enable = ~enable;
            if (!enable && $urandom_range(0, 9) < 3) enable = 1'b1;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0; enable = 1'b0;
        step(5);

        checks++;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp<=1", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexing controller for the two-digit seven-segment display.
- Takes the MS/LS nibbles produced by the switch-to-digit stage and owns the shared segment bus.
- Alternates the two digits with a programmable dwell and a blanking gap between them to suppress ghosting.
- Updates displayed values only at frame boundaries (no tearing); decodes hex 0-F and optionally blanks a leading zero.

Parameters:
- DIGIT_CYCLES, 12000, clk cycles each digit is lit (1 kHz per digit at 12 MHz); must be >= 2.
- BLANK_CYCLES, 120, clk cycles of all-segments-off between digits; must be >= 1.
- SEG_ACTIVE_LOW, 1, 1 = segment on is driven 0; 0 = segment on is driven 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  1 = scanning; 0 = display dark, FSM idle
- nibble_ms  in  4  most significant digit value
- nibble_ls  in  4  least significant digit value
- load  in  1  single-cycle strobe: capture nibbles for the next frame
- lz_blank  in  1  1 = blank MS digit when its displayed value is 0
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dig_sel  out  1  0 = LS digit driven, 1 = MS digit driven
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Clocking/reset: single clock clk; rst is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state = IDLE; dwell counter = 0.
  - stage_ms/ls = 0, shadow_ms/ls = 0, pending = 0.
  - seg = all off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - dig_sel = 0; frame_tick = 0.
- States: IDLE, SHOW_LS, BLANK_A, SHOW_MS, BLANK_B.
- Dwell counter: counts 0..N-1 in each state, where N = DIGIT_CYCLES for SHOW_* and BLANK_CYCLES for BLANK_*. It advances to the next state when the count reaches N-1 and resets to 0 on every state change. Width = $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)).
- Transitions:
  - IDLE -> SHOW_LS when enable = 1.
  - SHOW_LS -> BLANK_A -> SHOW_MS -> BLANK_B -> SHOW_LS, repeating.
  - Frame length = 2*(DIGIT_CYCLES + BLANK_CYCLES) cycles.
- enable = 0 in any state: next state is IDLE, counter cleared. Re-enable always restarts at SHOW_LS with count 0.
- Frame boundary: any entry into SHOW_LS, whether from IDLE or BLANK_B.
  - frame_tick is 1 in the first cycle the state register holds SHOW_LS.
  - On the boundary, if pending = 1: shadow <= stage and pending <= 0.
- load handling:
  - load = 1 captures nibble_ms/nibble_ls into stage and sets pending.
  - load on the boundary cycle itself: inputs bypass directly into shadow, pending stays 0.
  - Multiple loads within one frame: last one wins.
- Outputs are registered and follow the state register by one cycle:
  - SHOW_LS: seg = decode(shadow_ls), dig_sel = 0.
  - SHOW_MS: seg = decode(shadow_ms), dig_sel = 1. If lz_blank = 1 and shadow_ms = 0, seg = off.
  - BLANK_A/BLANK_B/IDLE: seg = off, dig_sel holds its last value.
- dig_sel changes only while seg is off, so no digit is ever driven with the other digit's pattern.
- Decode (active-high {g..a}):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Inverted when SEG_ACTIVE_LOW = 1.
- lz_blank is sampled every cycle; it is not shadowed.

Decomposition:
- Shared package seven_seg_pkg:
  - state encoding constants (IDLE..BLANK_B)
  - SEG_OFF_* constants
  - 16-entry segment decode function
- Sub-module seven_seg_decode: combinational nibble -> 7-bit active-high pattern; polarity is applied in seven_seg_scan.
- Everything else (FSM, counter, stage/shadow registers) is flat in seven_seg_scan.

Test Plan (DIGIT_CYCLES = 4, BLANK_CYCLES = 2, SEG_ACTIVE_LOW = 1):
- Reset then enable = 1, no load -> frame_tick every 12 cycles. seg = 7'h40 (digit 0) with dig_sel = 0 for 4 cycles, 7'h7F for 2, 7'h40 with dig_sel = 1 for 4, 7'h7F for 2.
- load with ms = 4'h3, ls = 4'hA mid-SHOW_MS -> current frame still shows 0/0. From the next frame, LS = 7'h08 ('A') and MS = 7'h30 ('3').
- load on the exact frame_tick cycle with ms = 1, ls = 2 -> that same frame shows 2 then 1 (bypass); pending stays 0.
- lz_blank = 1 with ms = 0, ls = 5 -> LS = 7'h12; MS window seg = 7'h7F while dig_sel = 1. Same with ms = 7 -> MS = 7'h78.
- enable dropped during SHOW_MS -> seg = 7'h7F within 2 cycles, no frame_tick. Re-enable -> frame_tick on entry, SHOW_LS starts at count 0.
- rst asserted mid-BLANK_A with pending = 1 -> all outputs at reset values the next cycle. Shadow and pending cleared, so display shows 0/0 after re-enable.
